serial_frame_tx: RTL

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Serialises one DATA_W-bit payload per frame onto line b. Frame
//            layout is preamble (PRE_W bits of PRE_VAL, MSB first), payload
//            (MSB first), then one stop bit of 0. Every bit is held for one
//            tick period. A new word offered on the stop-bit tick starts the
//            next preamble immediately, so back-to-back frames have no gap.
// Ports    : CLK        clock, rising edge
//            Rst        synchronous active-high reset
//            tick       bit-rate enable
//            din        payload word, captured on the accept edge
//            din_valid  payload offered
//            din_ready  combinational: tick & (IDLE | STOP)
//            b          registered serial line, idles at 0
//            busy       registered, high while a frame is in flight
//            done       registered one-cycle pulse at frame completion
// Revision : 1.0  initial release
// ============================================================================
module serial_frame_tx #(
  parameter int                 DATA_W  = 8,
  parameter int                 PRE_W   = 3,
  parameter logic [PRE_W-1:0]   PRE_VAL = 3'b101
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              tick,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              b,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2((DATA_W > PRE_W) ? DATA_W : PRE_W) + 1;
  localparam logic [CNT_W-1:0] c_pre_last  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sh;
  // Preamble is shifted out of its own register so no variable bit-select
  // of the parameter is needed.
  logic [PRE_W-1:0]  r_pre;
  logic              r_b;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;

  // A new word can only be taken when the line is free or carrying the
  // final stop bit, and only on a bit boundary.
  assign din_ready = tick & ((r_state == S_IDLE) | (r_state == S_STOP));
  assign w_accept  = din_valid & din_ready;

  assign b    = r_b;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge CLK) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_pre   <= '0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (tick) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_sh    <= din;
              r_pre   <= PRE_VAL << 1;
              r_b     <= PRE_VAL[PRE_W-1];
              r_cnt   <= c_pre_last;
              r_state <= S_PRE;
              r_busy  <= 1'b1;
            end
          end
          S_PRE: begin
            if (r_cnt == '0) begin
              r_b     <= r_sh[DATA_W-1];
              r_sh    <= r_sh << 1;
              r_cnt   <= c_data_last;
              r_state <= S_DATA;
            end else begin
              r_b   <= r_pre[PRE_W-1];
              r_pre <= r_pre << 1;
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_DATA: begin
            if (r_cnt == '0) begin
              r_b     <= 1'b0;
              r_state <= S_STOP;
            end else begin
              r_b   <= r_sh[DATA_W-1];
              r_sh  <= r_sh << 1;
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          default: begin
            // Stop bit has been held for its full period: frame complete.
            r_done <= 1'b1;
            if (w_accept) begin
              r_sh    <= din;
              r_pre   <= PRE_VAL << 1;
              r_b     <= PRE_VAL[PRE_W-1];
              r_cnt   <= c_pre_last;
              r_state <= S_PRE;
              r_busy  <= 1'b1;
            end else begin
              r_b     <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
